// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational signed 8x8 multiplier among NUM_REQ requesters.
// Optional: define MUL_SHARE_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).

module msb_complement (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // Sign-extend first so the multiply is done at full 16-bit width.
  assign p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
endmodule

module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_nxt;
  logic            any_valid;
  logic            grant;
  logic [7:0]      op_a, op_b;
  logic [15:0]     product;

  msb_complement u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Scan offsets from the far end back to 0 so the nearest valid index at/after ptr wins.
  // NOTE: every comb output gets a default first; a missed path would infer a latch.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // NOTE: state is updated with non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = any_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants open in IDLE or on a completing response; rst_n gating keeps req_ready low during reset.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    if (rst_n && any_valid && ((state == IDLE) || ((state == RESP) && rsp_ready))) begin
      grant              = 1'b1;
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      if (grant) begin
        op_a   <= req_a[8*int'(gnt_idx) +: 8];
        op_b   <= req_b[8*int'(gnt_idx) +: 8];
        rsp_id <= gnt_idx;
        ptr    <= ptr_nxt;
      end
      if (state == CALC) rsp_data <= product;
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                cnt <= '0;
      else if (req_valid[i] && req_ready[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign grant_cnt[16*i +: 16] = cnt;
  end
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational signed 8x8 multiplier (instance of msb_complement) among NUM_REQ requesters.
- Round-robin arbitration; each requester uses a valid/ready request channel.
- Single response channel carries product and requester ID, with backpressure.
- Sits between DSP/MAC clients and the multiplier so the multiplier is time-multiplexed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  8*NUM_REQ  signed operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NUM_REQ  signed operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- rsp_valid  out  1  response valid.
- rsp_data  out  16  signed product.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_ready  in  1  consumer accepts response.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, round-robin pointer=0, operand registers=0.
- States: IDLE, CALC, RESP.
- IDLE: if any req_valid, grant the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is driven combinationally high in that same cycle; only one bit may be high.
  - Operands of g and ID g are registered; pointer <= (g+1) mod NUM_REQ; next state CALC.
- CALC: one cycle.
  - Registered operands drive the multiplier.
  - Product registered into rsp_data; next state RESP. req_ready=0.
- RESP: rsp_valid=1; rsp_data and rsp_id held stable until rsp_valid && rsp_ready.
  - On handshake, if any req_valid, a new grant happens in the same cycle (req_ready high, operands captured), then go to CALC; otherwise go to IDLE.
  - Back-to-back throughput is therefore 1 result per 2 cycles.
- Latency: accept at edge T, rsp_valid high from T+2; minimum 2 cycles.
- Arithmetic: rsp_data equals the exact two's-complement product of the signed 8-bit operands.
  - Range -16256..16384; -128*-128=16384 (0x4000) and -128*127=-16256 (0xC080) must be exact.
- req_valid dropping before grant: no effect, no state recorded.
- req_ready is never asserted in CALC, or in RESP without a same-cycle rsp handshake.
- Requester i never granted twice while another valid requester is waiting (fairness bound: NUM_REQ grants).
- Reset mid-operation: in-flight result discarded, no rsp_valid after release, pointer returns to 0.
- Grant logic uses no latches; all state changes on the rising clk edge.

Optional Feature:
- Macro MUL_SHARE_ARB_STATS_EN.
- When defined, adds output port grant_cnt [16*NUM_REQ-1:0]: per-requester 16-bit saturating counters.
  - Counter increments on each accepted request (req_valid[i] && req_ready[i]).
  - Counters saturate at 0xFFFF and are cleared by reset.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single request: req0 a=-128, b=-128, rsp_ready=1 -> req_ready[0] at T, rsp_valid at T+2, rsp_data=16384, rsp_id=0.
- Sign cases: (-7,6)->-42, (127,-128)->-16256, (-1,-1)->1, (0,-55)->0, each with rsp_id matching the requester.
- Round-robin: all 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0; a new grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_data/rsp_id stable, no req_ready pulses; release -> handshake plus same-cycle next grant.
- Reset mid-op: assert rst_n=0 during CALC -> all outputs 0 immediately; after release with no requests, rsp_valid stays 0.
- STATS_EN: 3 accepted from req2 and 1 from req0 -> grant_cnt[47:32]=3, grant_cnt[15:0]=1; counter preloaded near 0xFFFF holds at 0xFFFF after further grants.
